rf_param_dump: RTL and testbench
================================

Name: rf_param_dump

Overview:
- Parametrised successor to the single-issue 16x16 register file.
- Configurable data width, register depth and hardwired-zero option.
- Registered read ports with write-to-read bypass.
- Free-running cycle counter that freezes on halt.
- Halt-triggered, handshaked sequential dump port: the bench/trace unit streams out the architectural state instead of relying on simulation prints.
- Sits between decode (read addresses) and writeback (write port) in the core.

Parameters:
- WIDTH, 16: data width of each register and of the read/write/dump data.
- DEPTH, 16: number of registers. Power of two, ≥2. AW = log2(DEPTH).
- ZERO_REG, 1: 1 = register 0 always reads 0 and ignores writes. 0 = register 0 is ordinary.
- CNT_W, 16: width of the cycle counter.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- rs_addr, input, AW: read port A address.
- rt_addr, input, AW: read port B address.
- rd_addr, input, AW: write address.
- we, input, 1: write enable.
- wdata, input, WIDTH: write data.
- rs_data, output, WIDTH: read port A data, registered.
- rt_data, output, WIDTH: read port B data, registered.
- hlt, input, 1: halt request; its rising edge starts the dump.
- dump_valid, output, 1: dump_idx/dump_data valid.
- dump_ready, input, 1: consumer accepts the current dump beat.
- dump_idx, output, AW: index of the register being dumped.
- dump_data, output, WIDTH: contents of regs[dump_idx].
- dump_done, output, 1: all DEPTH registers dumped; sticky.
- cycle_count, output, CNT_W: cycles elapsed before halt.

Behaviour:
- Reset (rst_n low, asynchronous): all regs = 0, rs_data = rt_data = 0, dump_valid = 0, dump_idx = 0, dump_data = 0, dump_done = 0, cycle_count = 0, FSM = IDLE, hlt edge detector register = 0. Reset mid-dump aborts the dump and returns to IDLE.
- Write: at a rising edge with we=1 and FSM=IDLE, regs[rd_addr] <= wdata. If ZERO_REG=1 and rd_addr=0, the write is dropped. Writes in DUMP or DONE are ignored (state frozen).
- Read: one-cycle latency. At a rising edge, rs_data <= value of regs[rs_addr] as seen after this edge's write:
  - if a write is accepted this edge and rd_addr==rs_addr, the bypass gives wdata;
  - otherwise regs[rs_addr];
  - ZERO_REG=1 and rs_addr=0 gives 0 regardless.
  - rt_data behaves identically. Reads continue to update in all FSM states.
- Halt edge: hlt_q <= hlt each cycle; hlt_rise = hlt & ~hlt_q. hlt_rise is honoured only in IDLE.
- FSM:
  - IDLE: cycle_count += 1 each cycle, saturating at all-ones. On hlt_rise, go to DUMP with dump_idx = 0. cycle_count does not increment in that cycle.
  - DUMP: dump_valid = 1, dump_data = regs[dump_idx] (combinational from array). On dump_valid & dump_ready:
    - if dump_idx == DEPTH-1, go to DONE;
    - else dump_idx += 1.
    - Without dump_ready, dump_idx and dump_data hold stable.
  - DONE: dump_valid = 0, dump_done = 1, cycle_count frozen. Stays until reset; further hlt edges are ignored.
- Halt and write in the same cycle: the write is accepted (FSM still IDLE at that edge) and appears in the dump.
- Exactly DEPTH dump beats are produced, indices 0..DEPTH-1 in order, no gaps, no repeats.

Test Plan:
1. Reset, then write regs 1..15 = 0x1111·i (16'h1111, 16'h2222, …) and read each back on rs and rt. Data appears exactly one cycle after the address is presented; reg0 reads 0.
2. With rs_addr = rt_addr = 5, write rd_addr = 5, wdata = 16'hBEEF in the same cycle. The next cycle gives rs_data = rt_data = 16'hBEEF (bypass). Then write rd_addr = 0, wdata = 16'hFFFF; reads of 0 return 0 (ZERO_REG=1). With ZERO_REG=0, the read returns 16'hFFFF.
3. Hold hlt low for 100 cycles after reset, then raise it. cycle_count freezes at 100. Dump with dump_ready tied high gives 16 consecutive beats idx 0..15 with the data from test 1. dump_done rises the cycle after beat 15.
4. Backpressure: toggle dump_ready with pattern 1,0,0,1,… during the dump. dump_idx/dump_data are stable while ready is 0. Total of 16 accepted beats; no skipped or duplicated index.
5. Assert we with rd_addr = 3, wdata = 16'h1234 during DUMP. regs[3] is unchanged in the dump and in later reads. Pulse hlt again in DONE: no new dump, dump_done stays 1.
6. Drop rst_n asynchronously mid-dump at idx = 7 (no clock edge). All outputs clear immediately. After release, regs read 0 and a new hlt rise dumps all zeros.

Source files
------------

// File: rtl/rf_param_dump.sv
`default_nettype none
// ============================================================================
// rf_param_dump : parametrised register file with bypassed registered reads,
//                 saturating cycle counter and halt-triggered handshaked dump.
// Rev 1.0
// ============================================================================
module rf_param_dump #(
  parameter  int WIDTH    = 16,
  parameter  int DEPTH    = 16,
  parameter  int ZERO_REG = 1,
  parameter  int CNT_W    = 16,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rs_addr,
  input  logic [AW-1:0]    rt_addr,
  input  logic [AW-1:0]    rd_addr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  input  logic             hlt,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [AW-1:0]    dump_idx,
  output logic [WIDTH-1:0] dump_data,
  output logic             dump_done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DUMP = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hlt_q;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] rs_q, rs_d;
  logic [WIDTH-1:0] rt_q, rt_d;

  logic wr_acc;
  logic hlt_rise;

  // Architectural state is frozen once the dump has started.
  assign wr_acc   = we && (state_q == S_IDLE) && !((ZERO_REG != 0) && (rd_addr == '0));
  assign hlt_rise = hlt && !hlt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_acc) begin
      regs_q[rd_addr] <= wdata;
    end
  end

  // Reads see the value after this edge's write, so a same-cycle write bypasses.
  always_comb begin
    rs_d = regs_q[rs_addr];
    if (wr_acc && (rd_addr == rs_addr)) rs_d = wdata;
    if ((ZERO_REG != 0) && (rs_addr == '0)) rs_d = '0;
    rt_d = regs_q[rt_addr];
    if (wr_acc && (rd_addr == rt_addr)) rt_d = wdata;
    if ((ZERO_REG != 0) && (rt_addr == '0)) rt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q    <= '0;
      rt_q    <= '0;
      hlt_q   <= 1'b0;
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      hlt_q   <= hlt;
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (hlt_rise) begin
          state_d = S_DUMP;
          idx_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DUMP: begin
        if (dump_ready) begin
          if (idx_q == LAST_IDX) state_d = S_DONE;
          else                   idx_d   = idx_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rs_data     = rs_q;
  assign rt_data     = rt_q;
  assign dump_valid  = (state_q == S_DUMP);
  assign dump_done   = (state_q == S_DONE);
  assign dump_idx    = idx_q;
  assign dump_data   = dump_valid ? regs_q[idx_q] : '0;
  assign cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_param_dump.sv
`default_nettype none
// ============================================================================
// tb_rf_param_dump : directed table-driven bench for rf_param_dump.
// Rev 1.0
// ============================================================================
module tb_rf_param_dump;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  rs_addr = '0, rt_addr = '0, rd_addr = '0;
  logic        we = 1'b0, hlt = 1'b0, dump_ready = 1'b0;
  logic [15:0] wdata = '0;

  logic [15:0] rs_data, rt_data, dump_data, cycle_count;
  logic [3:0]  dump_idx;
  logic        dump_valid, dump_done;

  logic [15:0] z_rs_data, z_rt_data, z_dump_data, z_cycle_count;
  logic [3:0]  z_dump_idx;
  logic        z_dump_valid, z_dump_done;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  rf_param_dump #(.WIDTH(16), .DEPTH(16), .ZERO_REG(1), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .we(we), .wdata(wdata), .rs_data(rs_data),
    .rt_data(rt_data), .hlt(hlt), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data),
    .dump_done(dump_done), .cycle_count(cycle_count)
  );

  rf_param_dump #(.WIDTH(16), .DEPTH(16), .ZERO_REG(0), .CNT_W(16)) dut_z (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rd_addr(rd_addr), .we(we), .wdata(wdata), .rs_data(z_rs_data),
    .rt_data(z_rt_data), .hlt(hlt), .dump_valid(z_dump_valid),
    .dump_ready(dump_ready), .dump_idx(z_dump_idx), .dump_data(z_dump_data),
    .dump_done(z_dump_done), .cycle_count(z_cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [3:0]  rd;
    logic [15:0] wd;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [15:0] ers;
    logic [15:0] ert;
    logic [15:0] ezrs;
  } vec_t;

  vec_t vt[36];

  function automatic logic [15:0] f(int i);
    return 16'(i * 32'h1111);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    hlt = 1'b0; we = 1'b0; dump_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic write_all();
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; rd_addr = 4'(i); wdata = f(i);
      tick();
    end
    we = 1'b0;
  endtask

  initial begin
    int n;
    int exp_idx;
    int acc;
    logic pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    n = 0;
    for (int i = 1; i < 16; i++) begin
      vt[n] = '{1'b1, 4'(i), f(i), 4'(i), 4'(i - 1), f(i), f(i - 1), f(i)};
      n++;
    end
    for (int i = 0; i < 16; i++) begin
      vt[n] = '{1'b0, 4'd0, 16'h0, 4'(i), 4'(15 - i), f(i), f(15 - i), f(i)};
      n++;
    end
    vt[n] = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF}; n++;
    vt[n] = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 16'hBEEF, 16'hBEEF, 16'hBEEF}; n++;
    vt[n] = '{1'b1, 4'd0, 16'hFFFF, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFF}; n++;
    vt[n] = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'hFFFF}; n++;
    vt[n] = '{1'b1, 4'd5, 16'h5555, 4'd5, 4'd4, 16'h5555, 16'h4444, 16'h5555}; n++;

    // ---------------- reset values ----------------
    #1 rst_n = 1'b0;
    tick();
    chk("rst_rs", 32'(rs_data), 32'h0);
    chk("rst_rt", 32'(rt_data), 32'h0);
    chk("rst_valid", 32'(dump_valid), 32'h0);
    chk("rst_idx", 32'(dump_idx), 32'h0);
    chk("rst_done", 32'(dump_done), 32'h0);
    chk("rst_cnt", 32'(cycle_count), 32'h0);
    rst_n = 1'b1;
    cyc = 0;

    // ---------------- table: writes, reads, bypass, zero register ----------------
    for (int k = 0; k < n; k++) begin
      we = vt[k].we; rd_addr = vt[k].rd; wdata = vt[k].wd;
      rs_addr = vt[k].rs; rt_addr = vt[k].rt;
      tick();
      chk($sformatf("vec%0d_rs", k), 32'(rs_data), 32'(vt[k].ers));
      chk($sformatf("vec%0d_rt", k), 32'(rt_data), 32'(vt[k].ert));
      chk($sformatf("vec%0d_zrs", k), 32'(z_rs_data), 32'(vt[k].ezrs));
    end
    we = 1'b0; rs_addr = '0; rt_addr = '0;

    // ---------------- counter and dump with ready high ----------------
    while (cyc < 100) tick();
    chk("cnt_100", 32'(cycle_count), 32'd100);
    hlt = 1'b1; dump_ready = 1'b1;
    tick();
    chk("cnt_frozen_on_halt", 32'(cycle_count), 32'd100);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("a_valid%0d", k), 32'(dump_valid), 32'h1);
      chk($sformatf("a_idx%0d", k), 32'(dump_idx), 32'(k));
      chk($sformatf("a_data%0d", k), 32'(dump_data), 32'(f(k)));
      chk($sformatf("a_done_early%0d", k), 32'(dump_done), 32'h0);
      tick();
    end
    chk("a_done", 32'(dump_done), 32'h1);
    chk("a_valid_off", 32'(dump_valid), 32'h0);
    tick(); tick();
    chk("a_cnt_final", 32'(cycle_count), 32'd100);

    // ---------------- backpressure, write during dump, halt in DONE ----------------
    do_reset();
    chk("b_done_cleared", 32'(dump_done), 32'h0);
    for (int i = 1; i < 16; i++) begin
      we = 1'b1; rd_addr = 4'(i); wdata = f(i);
      if (i == 15) hlt = 1'b1;
      tick();
    end
    we = 1'b1; rd_addr = 4'd3; wdata = 16'h1234; rs_addr = 4'd3;
    exp_idx = 0; acc = 0;
    for (int j = 0; j < 200 && exp_idx < 16; j++) begin
      dump_ready = pat[j % 4];
      chk($sformatf("b_valid_j%0d", j), 32'(dump_valid), 32'h1);
      chk($sformatf("b_idx_j%0d", j), 32'(dump_idx), 32'(exp_idx));
      chk($sformatf("b_data_j%0d", j), 32'(dump_data), 32'(f(exp_idx)));
      if (j > 0) chk($sformatf("b_rs3_j%0d", j), 32'(rs_data), 32'(f(3)));
      tick();
      if (dump_ready) begin
        exp_idx++;
        acc++;
      end
    end
    chk("b_beats", 32'(acc), 32'd16);
    chk("b_done", 32'(dump_done), 32'h1);
    we = 1'b0; dump_ready = 1'b0; rt_addr = 4'd3;
    tick();
    chk("b_reg3_after", 32'(rt_data), 32'(f(3)));
    hlt = 1'b0; tick();
    hlt = 1'b1; tick(); tick();
    chk("b_rehalt_done", 32'(dump_done), 32'h1);
    chk("b_rehalt_valid", 32'(dump_valid), 32'h0);
    chk("b_cnt", 32'(cycle_count), 32'd14);

    // ---------------- asynchronous reset mid-dump ----------------
    do_reset();
    write_all();
    rs_addr = 4'd5; rt_addr = 4'd9; hlt = 1'b1; dump_ready = 1'b1;
    tick();
    for (int k = 0; k < 7; k++) tick();
    chk("c_idx7", 32'(dump_idx), 32'd7);
    chk("c_rs_before", 32'(rs_data), 32'(f(5)));
    #2 rst_n = 1'b0;
    #1;
    chk("c_async_valid", 32'(dump_valid), 32'h0);
    chk("c_async_idx", 32'(dump_idx), 32'h0);
    chk("c_async_data", 32'(dump_data), 32'h0);
    chk("c_async_rs", 32'(rs_data), 32'h0);
    chk("c_async_rt", 32'(rt_data), 32'h0);
    chk("c_async_cnt", 32'(cycle_count), 32'h0);
    hlt = 1'b0; dump_ready = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rs_addr = 4'(i); rt_addr = 4'(15 - i);
      tick();
      chk($sformatf("c_rd_rs%0d", i), 32'(rs_data), 32'h0);
      chk($sformatf("c_rd_rt%0d", i), 32'(rt_data), 32'h0);
    end
    hlt = 1'b1; dump_ready = 1'b1;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("c_idx%0d", k), 32'(dump_idx), 32'(k));
      chk($sformatf("c_data%0d", k), 32'(dump_data), 32'h0);
      chk($sformatf("c_valid%0d", k), 32'(dump_valid), 32'h1);
      tick();
    end
    chk("c_done", 32'(dump_done), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
